// File: rtl/sync_handshake_tx.sv
// Source side of a two-phase (toggle) req/ack clock-domain crossing.
// Holds a captured word on xfer_data, flips req_tgl and waits for the resynchronized ack toggle.
module sync_handshake_tx #(
    parameter int DW      = 32,
    parameter int NSYNC   = 2,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          req_tgl,
    output logic [DW-1:0] xfer_data,
    input  logic          ack_tgl,
    output logic          done,
    output logic          busy,
    output logic          timeout_err,
    input  logic          err_clr,
    output logic [CW-1:0] xfer_cnt
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
    localparam bit TMO_EN = (TIMEOUT != 0);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic          req_tgl_q, req_tgl_d;
    logic [DW-1:0] xfer_data_q, xfer_data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [CW-1:0] xfer_cnt_q, xfer_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_set_s;
    logic          ack_s;

    (* ASYNC_REG = "TRUE" *) logic [NSYNC-1:0] ack_sync_q;
    logic [NSYNC-1:0] ack_sync_d;

    assign ack_sync_d  = {ack_sync_q[NSYNC-2:0], ack_tgl};
    assign ack_s       = ack_sync_q[NSYNC-1];
    assign in_ready    = (state_q == IDLE) && (ack_s == req_tgl_q);
    assign busy        = (state_q == WAIT_ACK);
    assign req_tgl     = req_tgl_q;
    assign xfer_data   = xfer_data_q;
    assign done        = done_q;
    assign timeout_err = err_q;
    assign xfer_cnt    = xfer_cnt_q;

    // Next-state logic for the handshake FSM, timeout counter and sticky error.
    always_comb begin
        state_d     = state_q;
        req_tgl_d   = req_tgl_q;
        xfer_data_d = xfer_data_q;
        done_d      = 1'b0;
        xfer_cnt_d  = xfer_cnt_q;
        tmo_d       = tmo_q;
        err_set_s   = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (in_valid && in_ready) begin
                    xfer_data_d = in_data;
                    req_tgl_d   = ~req_tgl_q;
                    state_d     = WAIT_ACK;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_ACK: begin
                // An ack arriving on the saturating cycle takes priority over the error.
                if (ack_s == req_tgl_q) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    xfer_cnt_d = xfer_cnt_q + CW'(1);
                end else if (tmo_q != TMO_MAX) begin
                    tmo_d     = tmo_q + TW'(1);
                    err_set_s = TMO_EN && (tmo_q + TW'(1) == TMO_MAX);
                end else begin
                    tmo_d = tmo_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Ack toggle resynchronizer; nothing else looks at ack_tgl.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= ack_sync_d;
        end
    end

    // Handshake FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_tgl_q   <= 1'b0;
            xfer_data_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            xfer_cnt_q  <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_tgl_q   <= req_tgl_d;
            xfer_data_q <= xfer_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            xfer_cnt_q  <= xfer_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

endmodule
